// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer
// Receive-side bit-timing recovery for the USB full-speed receiver.
// A phase counter restarts at 0 on every falling edge of D+ (d_edge).
// It otherwise free-runs modulo CLKS_PER_BIT, so transmitter/receiver
// clock drift is absorbed. The block produces a mid-bit shift strobe and
// a one-cycle byte pulse after every 8 non-stuffed bits.

module usb_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,  // clk cycles per bit cell, 4..16
    parameter int unsigned SAMPLE_POINT = 3   // strobe phase, 1..CLKS_PER_BIT-1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_edge,
    input  logic rcving,
    input  logic stuff,
    output logic shift_enable,
    output logic byte_received
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] LAST_PHASE   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_PHASE = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] PHASE_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_phase;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             byte_received_q, byte_received_d;

    // Sample strobe: the phase counter is idle-cleared, so qualifying with
    // rcving keeps the strobe low in idle and during reset. An edge cycle is
    // phase 0 by definition, so any strobe pending in that cycle is dropped.
    assign shift_enable  = rcving & ~d_edge & (cnt_q == SAMPLE_PHASE);
    assign byte_received = byte_received_q;

    // Next-state logic for phase, bit count and the byte pulse.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d           = '0;
        bit_cnt_d       = '0;
        byte_received_d = 1'b0;
        eff_phase       = d_edge ? '0 : cnt_q;

        if (rcving) begin
            // Edge restarts the bit cell; otherwise continue from the held phase.
            cnt_d = (eff_phase == LAST_PHASE) ? '0 : (eff_phase + PHASE_ONE);

            // Stuffed bits are shifted by the decoder but never counted.
            bit_cnt_d = bit_cnt_q;
            if (shift_enable && !stuff) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            // Registered so the pulse trails the 8th strobe by one cycle,
            // after the shift register has captured bit 7.
            byte_received_d = shift_enable & ~stuff & (bit_cnt_q == 3'd7);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            byte_received_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_received_q <= byte_received_d;
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb_usb_rx_bit_timer
// Directed scenarios for usb_rx_bit_timer at CLKS_PER_BIT=8, SAMPLE_POINT=3.
// Each scenario describes its stimulus with per-cycle tables (edge, stuff,
// idle). The expected strobe and byte-pulse cycles, worked out by hand from
// the bit-timing rules, go into queues that are popped as the DUT runs.
// Cycle 0 is the first cycle with rcving=1 after a reset.

module tb_usb_rx_bit_timer;

    localparam int MAX_CYC = 200;

    logic clk;
    logic n_rst;
    logic d_edge;
    logic rcving;
    logic stuff;
    logic shift_enable;
    logic byte_received;

    int checks;
    int failures;

    int se_q[$];
    int br_q[$];
    bit edge_at[MAX_CYC];
    bit stuff_at[MAX_CYC];
    bit idle_at[MAX_CYC];

    usb_rx_bit_timer #(
        .CLKS_PER_BIT(8),
        .SAMPLE_POINT(3)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .rcving       (rcving),
        .stuff        (stuff),
        .shift_enable (shift_enable),
        .byte_received(byte_received)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_tables();
        se_q.delete();
        br_q.delete();
        for (int i = 0; i < MAX_CYC; i++) begin
            edge_at[i]  = 1'b0;
            stuff_at[i] = 1'b0;
            idle_at[i]  = 1'b0;
        end
    endtask

    task automatic push_strobes(input int first, input int step, input int last);
        for (int c = first; c <= last; c += step) se_q.push_back(c);
    endtask

    // Pulse reset across two edges, check outputs held low, release just
    // after a rising edge so the next driven cycle is cycle 0.
    task automatic do_reset();
        n_rst  = 1'b0;
        rcving = 1'b1;
        d_edge = 1'b0;
        stuff  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_shift_enable", 32'(shift_enable), 32'd0);
        check("reset_byte_received", 32'(byte_received), 32'd0);
        n_rst = 1'b1;
    endtask

    // One sample per cycle at the falling edge; inputs change 1 time unit
    // after the rising edge.
    task automatic run_cycles(input string name, input int first, input int ncyc);
        bit exp_se;
        bit exp_br;
        for (int cyc = first; cyc < first + ncyc; cyc++) begin
            d_edge = edge_at[cyc];
            stuff  = stuff_at[cyc];
            rcving = ~idle_at[cyc];
            @(negedge clk);
            exp_se = (se_q.size() != 0) && (se_q[0] == cyc);
            exp_br = (br_q.size() != 0) && (br_q[0] == cyc);
            if (exp_se) void'(se_q.pop_front());
            if (exp_br) void'(br_q.pop_front());
            check($sformatf("%s_se_c%0d", name, cyc), 32'(shift_enable), 32'(exp_se));
            check($sformatf("%s_br_c%0d", name, cyc), 32'(byte_received), 32'(exp_br));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input string name);
        check($sformatf("%s_se_left", name), 32'(se_q.size()), 32'd0);
        check($sformatf("%s_br_left", name), 32'(br_q.size()), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_rst    = 1'b1;
        d_edge   = 1'b0;
        rcving   = 1'b0;
        stuff    = 1'b0;
        #2;

        // Free run; stuff is pulsed on non-strobe cycles and must be ignored.
        do_reset();
        clear_tables();
        for (int c = 0; c < MAX_CYC; c++) stuff_at[c] = (c % 8 == 5);
        push_strobes(3, 8, 129);
        br_q.push_back(60);
        br_q.push_back(124);
        run_cycles("free", 0, 130);
        check_drained("free");

        // Resync: edge at 14 pulls the phase back, strobe moves 19 -> 17.
        do_reset();
        clear_tables();
        edge_at[14] = 1'b1;
        push_strobes(3, 8, 11);
        push_strobes(17, 8, 69);
        br_q.push_back(58);
        run_cycles("resync", 0, 70);
        check_drained("resync");

        // Edge on the strobe cycle 11: strobe suppressed, fires at 14.
        do_reset();
        clear_tables();
        edge_at[11] = 1'b1;
        se_q.push_back(3);
        push_strobes(14, 8, 69);
        br_q.push_back(63);
        run_cycles("edge_on_se", 0, 70);
        check_drained("edge_on_se");

        // Stuffed bit at strobe 11: not counted, byte pulse moves to 68.
        do_reset();
        clear_tables();
        stuff_at[11] = 1'b1;
        push_strobes(3, 8, 74);
        br_q.push_back(68);
        run_cycles("stuffed", 0, 75);
        check_drained("stuffed");

        // Back-to-back edges 20..22: phase held at 0/1, next strobe at 25.
        do_reset();
        clear_tables();
        edge_at[20] = 1'b1;
        edge_at[21] = 1'b1;
        edge_at[22] = 1'b1;
        push_strobes(3, 8, 19);
        push_strobes(25, 8, 64);
        br_q.push_back(58);
        run_cycles("b2b_edges", 0, 65);
        check_drained("b2b_edges");

        // Abort: rcving low 30..39 discards the partial byte.
        do_reset();
        clear_tables();
        for (int c = 30; c < 40; c++) idle_at[c] = 1'b1;
        push_strobes(3, 8, 27);
        push_strobes(43, 8, 104);
        br_q.push_back(100);
        run_cycles("abort", 0, 105);
        check_drained("abort");

        // Async reset inside cycle 35, which would otherwise be a strobe cycle.
        do_reset();
        clear_tables();
        push_strobes(3, 8, 34);
        run_cycles("pre_rst", 0, 35);
        check_drained("pre_rst");
        d_edge = 1'b0;
        stuff  = 1'b0;
        rcving = 1'b1;
        #1;
        check("pre_rst_se_c35", 32'(shift_enable), 32'd1);
        n_rst = 1'b0;
        #1;
        check("async_rst_se", 32'(shift_enable), 32'd0);
        check("async_rst_br", 32'(byte_received), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        clear_tables();
        push_strobes(3, 8, 69);
        br_q.push_back(60);
        run_cycles("post_rst", 0, 70);
        check_drained("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
